// File: rtl/bmu_req_issuer.sv
// -----------------------------------------------------------------------------
// bmu_req_issuer
//
// Initiator-side controller for the bit-manipulation unit (BMU). Tagged
// requests are queued in a command FIFO and issued one per cycle onto a fully
// registered BMU input bus. A small shift register tracks {valid, tag} for each
// issued operation and captures result_ff/error when the BMU latency has
// elapsed. Captures go into a response FIFO that is drained in issue order over
// a tagged valid/ready port. Issue is credit-gated, so a capture always has a
// free response slot and no response can be dropped.
//
// Ports:
//   clk, rst_l           clock (posedge) and asynchronous active-low reset
//   cmd_*                request port (valid/ready), operands, op vector, CSR
//                        read enable/data and tag
//   a_in, b_in, ap,      registered BMU input bus; all zero in cycles with no
//   valid_in,            issue
//   csr_ren_in,
//   csr_rddata_in
//   scan_mode            tied to 0
//   result_ff, error     BMU outputs, sampled BMU_LAT cycles after valid_in
//   rsp_*                response port (valid/ready) with result, error, tag
//   err_count            saturating count of captured responses with error=1
//   idle                 nothing queued, nothing in flight, nothing to return
// -----------------------------------------------------------------------------
module bmu_req_issuer #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int BMU_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_l,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [21:0]      cmd_ap,
  input  logic             cmd_csr_ren,
  input  logic [31:0]      cmd_csr_rddata,
  input  logic [TAG_W-1:0] cmd_tag,

  output logic [31:0]      a_in,
  output logic [31:0]      b_in,
  output logic [21:0]      ap,
  output logic             valid_in,
  output logic             csr_ren_in,
  output logic [31:0]      csr_rddata_in,
  output logic             scan_mode,

  input  logic [31:0]      result_ff,
  input  logic             error,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_error,
  output logic [TAG_W-1:0] rsp_tag,

  output logic [7:0]       err_count,
  output logic             idle
);

  localparam int CAW   = $clog2(CMD_DEPTH);
  localparam int RAW   = $clog2(RSP_DEPTH);
  localparam int CMD_W = 32 + 32 + 22 + 1 + 32 + TAG_W;
  localparam int RSP_W = 32 + 1 + TAG_W;
  // Holds 0..BMU_LAT+1: the op on the bus plus one per tracker stage.
  localparam int IFW   = $clog2(BMU_LAT + 2);
  // Wide enough for any credit sum without overflow.
  localparam int CW    = 16;

  // ---------------------------------------------------------------------------
  // Command FIFO (extra pointer bit separates full from empty)
  // ---------------------------------------------------------------------------
  logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
  logic [CAW:0]     cmd_wr_ptr_reg;
  logic [CAW:0]     cmd_rd_ptr_reg;
  logic             cmd_empty;
  logic             cmd_full;
  logic             cmd_push;
  logic [CMD_W-1:0] cmd_head;

  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [21:0]      head_ap;
  logic             head_csr_ren;
  logic [31:0]      head_csr_rddata;
  logic [TAG_W-1:0] head_tag;

  assign cmd_empty = (cmd_wr_ptr_reg == cmd_rd_ptr_reg);
  assign cmd_full  = (cmd_wr_ptr_reg[CAW] != cmd_rd_ptr_reg[CAW]) &&
                     (cmd_wr_ptr_reg[CAW-1:0] == cmd_rd_ptr_reg[CAW-1:0]);
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && !cmd_full;
  assign cmd_head  = cmd_mem[cmd_rd_ptr_reg[CAW-1:0]];

  assign {head_a, head_b, head_ap, head_csr_ren, head_csr_rddata, head_tag} = cmd_head;

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_ptr_reg[CAW-1:0]] <= {cmd_a, cmd_b, cmd_ap, cmd_csr_ren,
                                           cmd_csr_rddata, cmd_tag};
    end
  end

  // ---------------------------------------------------------------------------
  // Registered BMU bus and in-flight tracker
  // ---------------------------------------------------------------------------
  logic             valid_in_reg;
  logic [31:0]      a_in_reg;
  logic [31:0]      b_in_reg;
  logic [21:0]      ap_reg;
  logic             csr_ren_in_reg;
  logic [31:0]      csr_rddata_in_reg;
  logic [TAG_W-1:0] issue_tag_reg;

  // Stage 0 loads from the bus register, so the last stage lines up with the
  // cycle in which result_ff/error belong to that operation.
  logic             trk_valid_reg [BMU_LAT];
  logic [TAG_W-1:0] trk_tag_reg   [BMU_LAT];
  logic             cap_valid;
  logic [TAG_W-1:0] cap_tag;

  assign cap_valid = trk_valid_reg[BMU_LAT-1];
  assign cap_tag   = trk_tag_reg[BMU_LAT-1];

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [RSP_W-1:0] rsp_mem [RSP_DEPTH];
  logic [RAW:0]     rsp_wr_ptr_reg;
  logic [RAW:0]     rsp_rd_ptr_reg;
  logic [RAW:0]     rsp_count;
  logic             rsp_empty;
  logic             rsp_push;
  logic             rsp_pop;
  logic [RSP_W-1:0] rsp_head;

  assign rsp_count = rsp_wr_ptr_reg - rsp_rd_ptr_reg;
  assign rsp_empty = (rsp_wr_ptr_reg == rsp_rd_ptr_reg);
  assign rsp_push  = cap_valid;
  assign rsp_pop   = !rsp_empty && rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rd_ptr_reg[RAW-1:0]];

  // ---------------------------------------------------------------------------
  // Credit check and issue
  // ---------------------------------------------------------------------------
  logic [IFW-1:0] inflight;
  logic [CW-1:0]  credit_used;
  logic           issue;

  always_comb begin
    inflight = IFW'(valid_in_reg);
    for (int i = 0; i < BMU_LAT; i++) begin
      inflight = inflight + IFW'(trk_valid_reg[i]);
    end
  end

  // Every issued-but-unreturned op owns one response slot. A pop this cycle
  // frees its slot immediately, so a full response FIFO that is being drained
  // still lets one op issue in the same cycle.
  always_comb begin
    credit_used = CW'(rsp_count) - CW'(rsp_pop) + CW'(inflight);
    issue       = !cmd_empty && (credit_used < CW'(RSP_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cmd_wr_ptr_reg <= '0;
      cmd_rd_ptr_reg <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr_reg <= cmd_wr_ptr_reg + 1'b1;
      if (issue)    cmd_rd_ptr_reg <= cmd_rd_ptr_reg + 1'b1;
    end
  end

  // The bus returns to all-zero in any cycle without an issue.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_in_reg      <= 1'b0;
      a_in_reg          <= '0;
      b_in_reg          <= '0;
      ap_reg            <= '0;
      csr_ren_in_reg    <= 1'b0;
      csr_rddata_in_reg <= '0;
      issue_tag_reg     <= '0;
    end else if (issue) begin
      valid_in_reg      <= 1'b1;
      a_in_reg          <= head_a;
      b_in_reg          <= head_b;
      ap_reg            <= head_ap;
      csr_ren_in_reg    <= head_csr_ren;
      csr_rddata_in_reg <= head_csr_rddata;
      issue_tag_reg     <= head_tag;
    end else begin
      valid_in_reg      <= 1'b0;
      a_in_reg          <= '0;
      b_in_reg          <= '0;
      ap_reg            <= '0;
      csr_ren_in_reg    <= 1'b0;
      csr_rddata_in_reg <= '0;
      issue_tag_reg     <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < BMU_LAT; i++) begin
        trk_valid_reg[i] <= 1'b0;
        trk_tag_reg[i]   <= '0;
      end
    end else begin
      for (int i = BMU_LAT - 1; i > 0; i--) begin
        trk_valid_reg[i] <= trk_valid_reg[i-1];
        trk_tag_reg[i]   <= trk_tag_reg[i-1];
      end
      trk_valid_reg[0] <= valid_in_reg;
      trk_tag_reg[0]   <= issue_tag_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO storage, pointers and error counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_mem[rsp_wr_ptr_reg[RAW-1:0]] <= {result_ff, error, cap_tag};
    end
  end

  logic [7:0] err_count_reg;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rsp_wr_ptr_reg <= '0;
      rsp_rd_ptr_reg <= '0;
      err_count_reg  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr_reg <= rsp_wr_ptr_reg + 1'b1;
      if (rsp_pop)  rsp_rd_ptr_reg <= rsp_rd_ptr_reg + 1'b1;
      if (rsp_push && error && (err_count_reg != 8'hFF)) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign a_in          = a_in_reg;
  assign b_in          = b_in_reg;
  assign ap            = ap_reg;
  assign valid_in      = valid_in_reg;
  assign csr_ren_in    = csr_ren_in_reg;
  assign csr_rddata_in = csr_rddata_in_reg;
  assign scan_mode     = 1'b0;

  // Response fields read as zero while the FIFO is empty so that stale or
  // never-written storage never shows on the port.
  assign rsp_valid  = !rsp_empty;
  assign rsp_result = rsp_valid ? rsp_head[RSP_W-1 -: 32] : 32'd0;
  assign rsp_error  = rsp_valid ? rsp_head[TAG_W]         : 1'b0;
  assign rsp_tag    = rsp_valid ? rsp_head[TAG_W-1:0]     : '0;

  assign err_count = err_count_reg;
  assign idle      = cmd_empty && (inflight == '0) && rsp_empty;

endmodule

// File: tb/tb_bmu_req_issuer.sv
// -----------------------------------------------------------------------------
// tb_bmu_req_issuer
//
// Directed bench for bmu_req_issuer. A stub BMU answers each valid_in one cycle
// later with a_in+b_in and error=a_in[31] (and garbage when no op is active).
// A reference model keeps queues of accepted requests: the expected issue
// stream and the expected response stream, both in acceptance order. One
// monitor process checks the DUT against the model on every falling edge;
// the directed sequence adds literal expectations for each scenario.
// -----------------------------------------------------------------------------
module tb_bmu_req_issuer;

  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int TAG_W     = 4;
  localparam int BMU_LAT   = 1;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_a = '0;
  logic [31:0]      cmd_b = '0;
  logic [21:0]      cmd_ap = '0;
  logic             cmd_csr_ren = 1'b0;
  logic [31:0]      cmd_csr_rddata = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [31:0]      a_in;
  logic [31:0]      b_in;
  logic [21:0]      ap;
  logic             valid_in;
  logic             csr_ren_in;
  logic [31:0]      csr_rddata_in;
  logic             scan_mode;
  logic [31:0]      result_ff = '0;
  logic             error = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic             rsp_error;
  logic [TAG_W-1:0] rsp_tag;
  logic [7:0]       err_count;
  logic             idle;

  bmu_req_issuer #(
    .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W), .BMU_LAT(BMU_LAT)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_ap(cmd_ap), .cmd_csr_ren(cmd_csr_ren), .cmd_csr_rddata(cmd_csr_rddata),
    .cmd_tag(cmd_tag),
    .a_in(a_in), .b_in(b_in), .ap(ap), .valid_in(valid_in),
    .csr_ren_in(csr_ren_in), .csr_rddata_in(csr_rddata_in), .scan_mode(scan_mode),
    .result_ff(result_ff), .error(error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag),
    .err_count(err_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    chk_cnt++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Stub BMU with a one-cycle result latency.
  always @(posedge clk) begin : bmu_stub
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    v = valid_in;
    a = a_in;
    b = b_in;
    #1;
    if (v) begin
      result_ff = a + b;
      error     = a[31];
    end else begin
      result_ff = 32'hBAD0_BAD0;
      error     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare
  // ---------------------------------------------------------------------------
  logic [118:0]       exp_iss [$];   // {a, b, ap, csr_ren, csr_rddata}
  logic [36:0]        exp_rsp [$];   // {result, error, tag}
  int                 acc_cnt = 0;   // accepted requests
  int                 iss_cnt = 0;   // issues observed on the bus
  int                 pop_cnt = 0;   // responses consumed

  always @(negedge clk) begin : monitor
    logic [118:0] e;
    logic [36:0]  r;
    if (!rst_l) begin
      exp_iss.delete();
      exp_rsp.delete();
      acc_cnt = 0;
      iss_cnt = 0;
      pop_cnt = 0;
      chk("reset_outs_zero", |{valid_in, a_in, b_in, ap, csr_ren_in, csr_rddata_in,
                               scan_mode, rsp_valid, rsp_result, rsp_error, rsp_tag,
                               err_count}, 1'b0);
      chk("reset_cmd_ready", cmd_ready, 1'b1);
      chk("reset_idle", idle, 1'b1);
    end else begin
      if (valid_in) begin
        if (exp_iss.size() == 0) begin
          chk("issue_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_iss.pop_front();
          chk("issue_bus", {a_in, b_in, ap, csr_ren_in, csr_rddata_in}, e);
        end
        iss_cnt++;
      end else begin
        chk("bus_idle_zero", {a_in, b_in, ap, csr_ren_in, csr_rddata_in}, '0);
      end
      chk("scan_mode", scan_mode, 1'b0);
      chk("cmd_ready", cmd_ready, (acc_cnt - iss_cnt) < CMD_DEPTH);
      chk("credit_bound", (iss_cnt - pop_cnt) <= RSP_DEPTH, 1'b1);
      chk("idle", idle, acc_cnt == pop_cnt);
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          r = exp_rsp[0];
          chk("rsp_fields", {rsp_result, rsp_error, rsp_tag}, r);
          if (rsp_ready) begin
            void'(exp_rsp.pop_front());
            pop_cnt++;
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_iss.push_back({cmd_a, cmd_b, cmd_ap, cmd_csr_ren, cmd_csr_rddata});
        exp_rsp.push_back({cmd_a + cmd_b, cmd_a[31], cmd_tag});
        acc_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] a, input logic [31:0] b,
                         input logic [21:0] opv, input logic [TAG_W-1:0] tag);
    cmd_a          = a;
    cmd_b          = b;
    cmd_ap         = opv;
    cmd_tag        = tag;
    cmd_csr_ren    = tag[0];
    cmd_csr_rddata = {28'h0, tag} ^ 32'h0000_5A00;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [21:0] opv, input logic [TAG_W-1:0] tag);
    logic got;
    got = 1'b0;
    set_cmd(a, b, opv, tag);
    cmd_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      got = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    if (!got) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(output int pops, output logic [7:0] err_bits);
    pops     = 0;
    err_bits = '0;
    for (int k = 0; k < 400 && !idle; k++) begin
      if (rsp_valid && rsp_ready) begin
        err_bits = {err_bits[6:0], rsp_error};
        pops++;
      end
      step();
    end
    chk("drain_reaches_idle", idle, 1'b1);
  endtask

  localparam logic [21:0] AP_OP = 22'h000800;   // arbitrary op bit; stub always adds

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : directed
    int          acc;
    int          vi;
    int          pops;
    logic [7:0]  eb;
    logic        ev;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;
    step();

    // Single add: 5 + 7, tag 3
    rsp_ready = 1'b1;
    set_cmd(32'd5, 32'd7, AP_OP, 4'd3);
    cmd_valid = 1'b1;
    step();                                        // accepted at E0
    cmd_valid = 1'b0;
    chk("add_vi_before", valid_in, 1'b0);
    step();                                        // after E1
    chk("add_vi_issue", valid_in, 1'b1);
    chk("add_a_in", a_in, 32'd5);
    chk("add_ap", ap, 22'h000800);
    step();                                        // after E2
    chk("add_vi_single_cycle", valid_in, 1'b0);
    chk("add_rsp_not_yet", rsp_valid, 1'b0);
    step();                                        // after E3
    chk("add_rsp_valid", rsp_valid, 1'b1);
    chk("add_rsp_result", rsp_result, 32'd12);
    chk("add_rsp_tag", rsp_tag, 4'd3);
    chk("add_rsp_error", rsp_error, 1'b0);
    drain(pops, eb);
    chk("add_pop_count", pops, 1);

    // Streaming: 8 back-to-back, tags 0..7
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 8) begin
        set_cmd(32'(cyc) * 32'd11, 32'(cyc) + 32'd100, AP_OP >> cyc, 4'(cyc));
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      chk("stream_valid_in", valid_in, (cyc >= 1) && (cyc <= 8));
      ev = (cyc >= 3) && (cyc <= 10);
      chk("stream_rsp", {rsp_valid, rsp_valid ? rsp_tag : 4'd0},
                        {ev, ev ? 4'(cyc - 3) : 4'd0});
    end
    cmd_valid = 1'b0;
    drain(pops, eb);

    // Backpressure: rsp_ready low, 12 offered
    rsp_ready = 1'b0;
    acc = 0;
    vi  = 0;
    for (int k = 0; k < 20; k++) begin
      set_cmd(32'(acc) * 32'd3 + 32'd1, 32'd100, AP_OP, 4'(acc));
      cmd_valid = (acc < 12);
      ev = cmd_ready && cmd_valid;
      step();
      if (ev) acc++;
      if (valid_in) vi++;
    end
    cmd_valid = 1'b0;
    chk("bp_accepts", acc, 8);
    chk("bp_issues", vi, 4);
    chk("bp_cmd_ready_low", cmd_ready, 1'b0);
    chk("bp_valid_in_low", valid_in, 1'b0);
    chk("bp_rsp_held", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
    rsp_ready = 1'b1;
    drain(pops, eb);
    chk("bp_completions", pops, 8);

    // Error on the 2nd of 3 ops
    send(32'd10, 32'd1, AP_OP, 4'd9);
    send(32'h8000_0010, 32'd1, AP_OP, 4'd10);
    send(32'd20, 32'd1, AP_OP, 4'd11);
    drain(pops, eb);
    chk("err_pattern", eb[2:0], 3'b010);
    chk("err_count_one", err_count, 8'd1);

    // 300 erroring ops saturate the counter
    acc = 0;
    for (int k = 0; k < 2000 && acc < 300; k++) begin
      set_cmd(32'h8000_0000 | 32'(acc), 32'd2, AP_OP, 4'(acc));
      cmd_valid = 1'b1;
      ev = cmd_ready;
      step();
      if (ev) acc++;
    end
    cmd_valid = 1'b0;
    chk("sat_accepts", acc, 300);
    drain(pops, eb);
    chk("err_count_sat", err_count, 8'd255);

    // Reset with ops in flight and queued
    rsp_ready = 1'b0;
    send(32'd1, 32'd1, AP_OP, 4'd1);
    send(32'd2, 32'd2, AP_OP, 4'd2);
    send(32'd3, 32'd3, AP_OP, 4'd3);
    send(32'd4, 32'd4, AP_OP, 4'd4);
    chk("rst_pre_busy", idle, 1'b0);
    rst_l = 1'b0;
    #1;
    chk("rst_async_zero", |{valid_in, a_in, b_in, ap, csr_ren_in, csr_rddata_in,
                            rsp_valid, rsp_result, rsp_error, rsp_tag, err_count}, 1'b0);
    chk("rst_async_idle", idle, 1'b1);
    chk("rst_async_cmd_ready", cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_l     = 1'b1;
    rsp_ready = 1'b1;
    vi = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_valid || valid_in) vi++;
    end
    chk("rst_no_activity", vi, 0);
    chk("rst_idle_after", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
